// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, trap-cause, opcode and mux-select encodings for the multicycle controller
package mc_ctrl_pkg;

  typedef logic [3:0] state_e;

  localparam state_e S_FETCH    = 4'd0;
  localparam state_e S_DECODE   = 4'd1;
  localparam state_e S_MEMADR   = 4'd2;
  localparam state_e S_MEMREAD  = 4'd3;
  localparam state_e S_MEMWB    = 4'd4;
  localparam state_e S_MEMWRITE = 4'd5;
  localparam state_e S_EXECR    = 4'd6;
  localparam state_e S_EXECI    = 4'd7;
  localparam state_e S_ALUWB    = 4'd8;
  localparam state_e S_BEQ      = 4'd9;
  localparam state_e S_JAL      = 4'd10;
  localparam state_e S_JALR     = 4'd11;
  localparam state_e S_LUI      = 4'd12;
  localparam state_e S_AUIPC    = 4'd13;
  localparam state_e S_TRAP     = 4'd14;
  localparam state_e S_HALT     = 4'd15;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL     = 2'b00,
    CAUSE_ECALL       = 2'b01,
    CAUSE_EBREAK      = 2'b10,
    CAUSE_BUS_TIMEOUT = 2'b11
  } trap_cause_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] RES_TRAPVEC = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       mem_req;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       link_sel;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       trap_valid;
  } ctrl_t;

endpackage

// File: rtl/mc_imm_dec.sv
// rtl/mc_imm_dec.sv - opcode to immediate-format select, purely combinational
module mc_imm_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [2:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_STORE:          o_imm_src = IMM_S;
      OP_BRANCH:         o_imm_src = IMM_B;
      OP_JAL:            o_imm_src = IMM_J;
      OP_LUI, OP_AUIPC:  o_imm_src = IMM_U;
      default:           o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - multicycle RV32I main controller with memory handshake, timeout and traps
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT    = 16,
  parameter int HALT_ON_EBREAK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       sys_imm0,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       LinkSel,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       trap_valid,
  output logic [1:0] trap_cause,
  output logic       halted
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e         r_state;
  state_e         w_next;
  logic [CW-1:0]  r_cnt;
  trap_cause_e    r_trap_cause;
  trap_cause_e    w_cause;
  logic           w_req;
  logic           w_timeout;
  ctrl_t          w_dec;
  ctrl_t          w_ctrl;

  mc_imm_dec u_imm_dec (
    .i_op      (op),
    .o_imm_src (ImmSrc)
  );

  assign w_req     = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_timeout = (MEM_TIMEOUT != 0) && w_req && !mem_ready && (r_cnt == CNT_LAST);

  always_comb begin
    w_next  = r_state;
    w_cause = CAUSE_BUS_TIMEOUT;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_IALU:           w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          OP_SYSTEM: begin
            if (!sys_imm0) begin
              w_next  = S_TRAP;
              w_cause = CAUSE_ECALL;
            end else if (HALT_ON_EBREAK != 0) begin
              w_next  = S_HALT;
            end else begin
              w_next  = S_TRAP;
              w_cause = CAUSE_EBREAK;
            end
          end
          default: begin
            w_next  = S_TRAP;
            w_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEMWRITE: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_EXECR, S_EXECI, S_LUI, S_AUIPC:                  w_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_TRAP:    w_next = S_FETCH;
      S_HALT:                                           w_next = S_HALT;
      default:                                          w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_dec = '0;
    case (r_state)
      S_FETCH: begin
        w_dec.mem_req    = 1'b1;
        w_dec.ir_write   = mem_ready;
        w_dec.pc_update  = mem_ready;
        w_dec.alu_src_a  = SRCA_PC;
        w_dec.alu_src_b  = SRCB_FOUR;
        w_dec.alu_op     = ALUOP_ADD;
        w_dec.result_src = RES_ALURES;
      end
      S_DECODE: begin
        w_dec.alu_src_a = SRCA_OLDPC;
        w_dec.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        w_dec.alu_src_a = SRCA_RS1;
        w_dec.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_dec.mem_req = 1'b1;
        w_dec.adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_dec.result_src = RES_DATA;
        w_dec.reg_write  = 1'b1;
      end
      // The store strobe is withdrawn in the timeout cycle so the aborted write never lands.
      S_MEMWRITE: begin
        w_dec.mem_req   = 1'b1;
        w_dec.adr_src   = 1'b1;
        w_dec.mem_write = !w_timeout;
      end
      S_EXECR: begin
        w_dec.alu_src_a = SRCA_RS1;
        w_dec.alu_src_b = SRCB_RS2;
        w_dec.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_dec.alu_src_a = SRCA_RS1;
        w_dec.alu_src_b = SRCB_IMM;
        w_dec.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_dec.result_src = RES_ALUOUT;
        w_dec.reg_write  = 1'b1;
      end
      S_BEQ: begin
        w_dec.alu_src_a  = SRCA_RS1;
        w_dec.alu_src_b  = SRCB_RS2;
        w_dec.alu_op     = ALUOP_SUB;
        w_dec.result_src = RES_ALUOUT;
        w_dec.branch     = 1'b1;
      end
      S_JAL: begin
        w_dec.result_src = RES_ALUOUT;
        w_dec.pc_update  = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.link_sel   = 1'b1;
      end
      S_JALR: begin
        w_dec.alu_src_a  = SRCA_RS1;
        w_dec.alu_src_b  = SRCB_IMM;
        w_dec.result_src = RES_ALURES;
        w_dec.pc_update  = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.link_sel   = 1'b1;
      end
      S_LUI: begin
        w_dec.alu_src_a = SRCA_ZERO;
        w_dec.alu_src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        w_dec.alu_src_a = SRCA_OLDPC;
        w_dec.alu_src_b = SRCB_IMM;
      end
      S_TRAP: begin
        w_dec.trap_valid = 1'b1;
        w_dec.result_src = RES_TRAPVEC;
        w_dec.pc_update  = 1'b1;
      end
      default: w_dec = '0;
    endcase
  end

  // Gating with rst_n drops the bus request and store strobe the moment reset asserts.
  assign w_ctrl     = rst_n ? w_dec : '0;
  assign mem_req    = w_ctrl.mem_req;
  assign PCUpdate   = w_ctrl.pc_update;
  assign Branch     = w_ctrl.branch;
  assign AdrSrc     = w_ctrl.adr_src;
  assign IRWrite    = w_ctrl.ir_write;
  assign MemWrite   = w_ctrl.mem_write;
  assign RegWrite   = w_ctrl.reg_write;
  assign LinkSel    = w_ctrl.link_sel;
  assign ResultSrc  = w_ctrl.result_src;
  assign ALUSrcA    = w_ctrl.alu_src_a;
  assign ALUSrcB    = w_ctrl.alu_src_b;
  assign ALUOp      = w_ctrl.alu_op;
  assign trap_valid = w_ctrl.trap_valid;
  assign trap_cause = r_trap_cause;
  assign halted     = (r_state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_cnt        <= '0;
      r_trap_cause <= CAUSE_ILLEGAL;
    end else begin
      r_state <= w_next;
      if ((w_next == S_TRAP) && (r_state != S_TRAP))
        r_trap_cause <= w_cause;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_req && !mem_ready)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb/tb_mc_main_fsm.sv - directed self-checking bench for mc_main_fsm
module tb_mc_main_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       sys_imm0;
  logic       mem_ready;
  logic       mem_req, PCUpdate, Branch, AdrSrc, IRWrite, MemWrite, RegWrite, LinkSel;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       trap_valid;
  logic [1:0] trap_cause;
  logic       halted;

  int n_checks = 0;
  int n_errors = 0;

  mc_main_fsm #(.MEM_TIMEOUT(16), .HALT_ON_EBREAK(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .sys_imm0   (sys_imm0),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCUpdate   (PCUpdate),
    .Branch     (Branch),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .LinkSel    (LinkSel),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .trap_valid (trap_valid),
    .trap_cause (trap_cause),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req,PCUpdate,Branch,AdrSrc, IRWrite,MemWrite,RegWrite,LinkSel, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, trap_valid, halted}
  logic [17:0] w_obs;
  assign w_obs = {mem_req, PCUpdate, Branch, AdrSrc, IRWrite, MemWrite, RegWrite, LinkSel,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, trap_valid, halted};

  localparam logic [17:0] E_RST    = 18'b0000_0000_00_00_00_00_0_0;
  localparam logic [17:0] E_FWAIT  = 18'b1000_0000_10_00_10_00_0_0;
  localparam logic [17:0] E_FRDY   = 18'b1100_1000_10_00_10_00_0_0;
  localparam logic [17:0] E_DECODE = 18'b0000_0000_00_01_01_00_0_0;
  localparam logic [17:0] E_MEMADR = 18'b0000_0000_00_10_01_00_0_0;
  localparam logic [17:0] E_MRD    = 18'b1001_0000_00_00_00_00_0_0;
  localparam logic [17:0] E_MEMWB  = 18'b0000_0010_01_00_00_00_0_0;
  localparam logic [17:0] E_MWR    = 18'b1001_0100_00_00_00_00_0_0;
  localparam logic [17:0] E_MWR_TO = 18'b1001_0000_00_00_00_00_0_0;
  localparam logic [17:0] E_EXECR  = 18'b0000_0000_00_10_00_10_0_0;
  localparam logic [17:0] E_EXECI  = 18'b0000_0000_00_10_01_10_0_0;
  localparam logic [17:0] E_ALUWB  = 18'b0000_0010_00_00_00_00_0_0;
  localparam logic [17:0] E_BEQ    = 18'b0010_0000_00_10_00_01_0_0;
  localparam logic [17:0] E_JAL    = 18'b0100_0011_00_00_00_00_0_0;
  localparam logic [17:0] E_LUI    = 18'b0000_0000_00_11_01_00_0_0;
  localparam logic [17:0] E_TRAP   = 18'b0100_0000_11_00_00_00_1_0;
  localparam logic [17:0] E_HALT   = 18'b0000_0000_00_00_00_00_0_1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic rdy, input logic [17:0] exp, input string tag);
    mem_ready = rdy;
    #1;
    chk(tag, 32'(w_obs), 32'(exp));
    tick();
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0; sys_imm0 = 1'b0; mem_ready = 1'b1;
    tick();
    #1;
    chk("reset_outs", 32'(w_obs), 32'(E_RST));
    chk("reset_cause", 32'(trap_cause), 32'd0);
    rst_n = 1'b1;

    // R-type, immediate ready
    op = 7'b0110011;
    cyc(1'b1, E_FRDY,   "t1_fetch");
    cyc(1'b0, E_DECODE, "t1_decode");
    cyc(1'b0, E_EXECR,  "t1_execr");
    cyc(1'b0, E_ALUWB,  "t1_aluwb");

    // load with three wait cycles
    op = 7'b0000011;
    #1 chk("imm_load", 32'(ImmSrc), 32'd0);
    cyc(1'b1, E_FRDY,   "t2_fetch");
    cyc(1'b0, E_DECODE, "t2_decode");
    cyc(1'b0, E_MEMADR, "t2_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, E_MRD, "t2_memread_wait");
    cyc(1'b1, E_MRD,    "t2_memread_done");
    cyc(1'b0, E_MEMWB,  "t2_memwb");

    // store that never completes
    op = 7'b0100011;
    #1 chk("imm_store", 32'(ImmSrc), 32'd1);
    cyc(1'b1, E_FRDY,   "t3_fetch");
    cyc(1'b0, E_DECODE, "t3_decode");
    cyc(1'b0, E_MEMADR, "t3_memadr");
    for (int i = 0; i < 15; i++) cyc(1'b0, E_MWR, "t3_memwrite_wait");
    cyc(1'b0, E_MWR_TO, "t3_timeout_cycle");
    chk("t3_cause", 32'(trap_cause), 32'd3);
    cyc(1'b0, E_TRAP,   "t3_trap");

    // ready arriving on the last allowed fetch cycle wins over the timeout
    op = 7'b0110011;
    for (int i = 0; i < 15; i++) cyc(1'b0, E_FWAIT, "edge_fetch_wait");
    cyc(1'b1, E_FRDY,   "edge_fetch_ready");
    cyc(1'b0, E_DECODE, "edge_decode");
    cyc(1'b0, E_EXECR,  "edge_execr");
    cyc(1'b0, E_ALUWB,  "edge_aluwb");

    op = 7'b0010011;
    cyc(1'b1, E_FRDY,   "ialu_fetch");
    cyc(1'b0, E_DECODE, "ialu_decode");
    cyc(1'b0, E_EXECI,  "ialu_execi");
    cyc(1'b0, E_ALUWB,  "ialu_aluwb");

    op = 7'b1100011;
    #1 chk("imm_branch", 32'(ImmSrc), 32'd2);
    cyc(1'b1, E_FRDY,   "beq_fetch");
    cyc(1'b0, E_DECODE, "beq_decode");
    cyc(1'b0, E_BEQ,    "beq_beq");

    op = 7'b1101111;
    #1 chk("imm_jal", 32'(ImmSrc), 32'd3);
    cyc(1'b1, E_FRDY,   "jal_fetch");
    cyc(1'b0, E_DECODE, "jal_decode");
    cyc(1'b0, E_JAL,    "jal_jal");

    op = 7'b0110111;
    #1 chk("imm_lui", 32'(ImmSrc), 32'd4);
    cyc(1'b1, E_FRDY,   "lui_fetch");
    cyc(1'b0, E_DECODE, "lui_decode");
    cyc(1'b0, E_LUI,    "lui_lui");
    cyc(1'b0, E_ALUWB,  "lui_aluwb");

    // illegal opcode, then ecall
    op = 7'b0000000;
    cyc(1'b1, E_FRDY,   "t4_ill_fetch");
    cyc(1'b0, E_DECODE, "t4_ill_decode");
    chk("t4_ill_cause", 32'(trap_cause), 32'd0);
    cyc(1'b0, E_TRAP,   "t4_ill_trap");
    op = 7'b1110011; sys_imm0 = 1'b0;
    cyc(1'b1, E_FRDY,   "t4_ecall_fetch");
    cyc(1'b0, E_DECODE, "t4_ecall_decode");
    chk("t4_ecall_cause", 32'(trap_cause), 32'd1);
    cyc(1'b0, E_TRAP,   "t4_ecall_trap");

    // ebreak halts; mem_ready is ignored while halted
    sys_imm0 = 1'b1;
    cyc(1'b1, E_FRDY,   "t5_fetch");
    cyc(1'b0, E_DECODE, "t5_decode");
    for (int i = 0; i < 20; i++) cyc(1'b1, E_HALT, "t5_halt");
    chk("t5_cause_held", 32'(trap_cause), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outs", 32'(w_obs), 32'(E_RST));
    tick();
    rst_n = 1'b1; sys_imm0 = 1'b0; op = 7'b0100011;
    cyc(1'b0, E_FWAIT,  "t5_restart_fetch");

    // reset asserted in the middle of a store
    cyc(1'b1, E_FRDY,   "t6_fetch");
    cyc(1'b0, E_DECODE, "t6_decode");
    cyc(1'b0, E_MEMADR, "t6_memadr");
    cyc(1'b0, E_MWR,    "t6_memwrite");
    mem_ready = 1'b0;
    #1;
    chk("t6_pre_memwrite", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_mem_req", 32'(mem_req), 32'd0);
    chk("t6_async_memwrite", 32'(MemWrite), 32'd0);
    tick();
    rst_n = 1'b1;
    cyc(1'b1, E_FRDY,   "t6_restart_fetch");
    cyc(1'b0, E_DECODE, "t6_restart_decode");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
